// File: rtl/chan_pkg.sv
// Shared definitions for the channel transmitter slice.
//   CHAN_WIDTH  : default packet width carried over the channel
//   tx_state_e  : transmitter FSM state encoding (also exported for debug)
//   clog2_f     : ceiling log2 helper for sizing pointers
package chan_pkg;

  localparam int unsigned CHAN_WIDTH = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_REQ     = 2'd2,
    ST_RELEASE = 2'd3
  } tx_state_e;

  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push_i, wdata_i : write request and data (ignored while full)
//   pop_i           : read request (ignored while empty)
//   rdata_o         : current head entry, valid while empty_o=0
//   full_o, empty_o : occupancy flags
module sync_fifo import chan_pkg::*; #(
  parameter int unsigned WIDTH = CHAN_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = clog2_f(DEPTH);

  // One extra pointer bit distinguishes full from empty when the
  // address bits are equal.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Push uses the pre-edge full flag, so a pop on the same edge does not
  // make room for a push that was already refused.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/chan_tx.sv
// Clocked producer for a 4-phase bundled-data req/ack channel.
// Packets arrive on a valid/ready port, are buffered in a FIFO and then
// sent one at a time: data is set up, req raised, ack awaited, req
// dropped, ack release awaited.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_data, in_valid   : packet input (accepted when in_ready=1)
//   in_ready            : FIFO not full
//   ch_req, ch_data     : channel request and bundled data (registered)
//   ch_ack              : channel acknowledge, asynchronous to clk
//   busy                : FIFO non-empty or a handshake in progress
//   sent_cnt            : completed handshakes, wraps
//   dbg_state           : current FSM state
// Handshake rules: an input packet transfers on a rising clk where
// in_valid=1 and in_ready=1; on the channel, ch_data is stable whenever
// ch_req=1 or the synchronized ack is 1, and a packet counts as sent once
// ack has returned to 0 after ch_req fell.
module chan_tx import chan_pkg::*; #(
  parameter int unsigned WIDTH = CHAN_WIDTH,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ch_req,
  input  logic             ch_ack,
  output logic [WIDTH-1:0] ch_data,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt,
  output tx_state_e        dbg_state
);

  tx_state_e        state_q;
  logic             ch_req_q;
  logic [WIDTH-1:0] ch_data_q;
  logic [CNT_W-1:0] sent_cnt_q;
  logic             ack_meta_q;
  logic             ack_s_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_pop;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid && !fifo_full),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Two-flop synchronizer; the FSM only ever looks at ack_s_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= ch_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  // A new packet is taken only with the channel fully released (ack_s=0).
  // From IDLE this also blocks a stale ack left over from before a reset.
  always_comb begin
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE, ST_RELEASE: fifo_pop = !fifo_empty && !ack_s_q;
      default:             fifo_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ch_req_q   <= 1'b0;
      ch_data_q  <= '0;
      sent_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            ch_data_q <= fifo_rdata;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // Data has had one full cycle to settle before req rises.
          ch_req_q <= 1'b1;
          state_q  <= ST_REQ;
        end
        ST_REQ: begin
          if (ack_s_q) begin
            ch_req_q <= 1'b0;
            state_q  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!ack_s_q) begin
            sent_cnt_q <= sent_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (fifo_pop) begin
              ch_data_q <= fifo_rdata;
              state_q   <= ST_SETUP;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = !fifo_full;
  assign ch_req    = ch_req_q;
  assign ch_data   = ch_data_q;
  assign sent_cnt  = sent_cnt_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
